// File: rtl/bt_pkg.sv
// Shared constants for the Bluetooth jump receiver: rx FSM state codes,
// ASCII command/status bytes and the bit-period helper.
package bt_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_START     = 3'd1;
  localparam rx_state_t ST_DATA      = 3'd2;
  localparam rx_state_t ST_STOP      = 3'd3;
  localparam rx_state_t ST_WAIT_IDLE = 3'd4;

  localparam logic [7:0] CMD_JUMP_UC = 8'h4A;
  localparam logic [7:0] CMD_JUMP_LC = 8'h6A;
  localparam logic [7:0] STAT_ALIVE  = 8'h41;
  localparam logic [7:0] STAT_DEAD   = 8'h58;

  function automatic int bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bt_uart_tx.sv
// UART 8N1 byte transmitter: start accepted when not busy, frame is
// start(0), 8 data bits LSB first, stop(1), each BIT_CYC clocks long.
module bt_uart_tx #(
  parameter int BIT_CYC = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);

  logic [9:0]       frame;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q  <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
      end
    end else if (cnt == BIT_LAST) begin
      cnt <= '0;
      if (bit_idx == 4'd9) busy_q <= 1'b0;
      else                 bit_idx <= bit_idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame shifter carries no reset; tx is forced idle while not busy.
  always_ff @(posedge clk) begin
    if (!busy_q && start)            frame <= {1'b1, data, 1'b0};
    else if (busy_q && cnt == BIT_LAST) frame <= {1'b1, frame[9:1]};
  end

  assign tx   = busy_q ? frame[0] : 1'b1;
  assign busy = busy_q;

endmodule

// File: rtl/bt_jump_rx.sv
// HC-05 UART 8N1 receiver and 'J'/'j' jump decoder. Optional status
// transmitter of game_alive edges is built when BT_STATUS_TX_EN is defined.
module bt_jump_rx
  import bt_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int BAUD           = 9600,
  parameter int JUMP_PULSE_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       game_alive,
  output logic       jump_btn,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       tx
);

  localparam int BIT_CYC  = bit_cyc(CLK_HZ, BAUD);
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       jump_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state   <= ST_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            // Returning to IDLE here lets the next start edge be seen while rx_valid is high.
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_DATA && cnt == BIT_LAST) shift <= {rx_s, shift[7:1]};
  end

  // A repeated jump byte reloads the width counter, stretching the pulse.
  always_ff @(posedge clk) begin
    if (reset)
      jump_cnt <= '0;
    else if (rx_valid && (rx_data == CMD_JUMP_UC || rx_data == CMD_JUMP_LC))
      jump_cnt <= 8'(JUMP_PULSE_CYC);
    else if (jump_cnt != '0)
      jump_cnt <= jump_cnt - 1'b1;
  end

  assign jump_btn = (jump_cnt != '0);

`ifdef BT_STATUS_TX_EN
  logic       alive_q;
  logic       pend;
  logic [7:0] pend_code;
  logic       tx_start;
  logic       tx_busy;

  // Only the newest edge is held; an edge in the launch cycle re-arms pend.
  always_ff @(posedge clk) begin
    if (reset) begin
      alive_q <= 1'b1;
      pend    <= 1'b0;
    end else begin
      alive_q <= game_alive;
      if (game_alive != alive_q) pend <= 1'b1;
      else if (tx_start)         pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (game_alive != alive_q) pend_code <= game_alive ? STAT_ALIVE : STAT_DEAD;
  end

  assign tx_start = pend && !tx_busy;

  bt_uart_tx #(
    .BIT_CYC(BIT_CYC)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .start(tx_start),
    .data (pend_code),
    .tx   (tx),
    .busy (tx_busy)
  );
`else
  logic unused_game_alive;
  assign unused_game_alive = game_alive;
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_bt_jump_rx.sv
// Bench for bt_jump_rx with a shortened bit period (16 clocks per bit).
module tb_bt_jump_rx;

  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       game_alive = 1'b1;
  logic       jump_btn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       tx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         fe_cyc[$];
  int         j_cyc[$];

  bt_jump_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .JUMP_PULSE_CYC(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .game_alive(game_alive),
    .jump_btn(jump_btn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        v_cyc.push_back(cyc);
        v_dat.push_back(rx_data);
      end
      if (frame_err) fe_cyc.push_back(cyc);
      if (jump_btn)  j_cyc.push_back(cyc);
    end
  end

  function automatic bit is_jump(input logic [7:0] b);
    return (b == 8'h4A) || (b == 8'h6A);
  endfunction

  task automatic clear_log();
    v_cyc.delete(); v_dat.delete(); fe_cyc.delete(); j_cyc.delete();
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop, BIT);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (jump_btn !== 1'b0)   begin errors++; $display("FAIL reset_jump: got %b want 0", jump_btn); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    reset = 1'b0;
    hold(1'b1, 2 * BIT);
  endtask

  task automatic test_single();
    logic [7:0] got;
    clear_log();
    send_frame(8'h4A, 1'b1);
    hold(1'b1, 2 * BIT);
    got = (v_dat.size() > 0) ? v_dat[0] : 8'hxx;
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", v_cyc.size()); end
    checks++; if (got !== 8'h4A)      begin errors++; $display("FAIL single_data: got %h want 4a", got); end
    checks++; if (rx_data !== 8'h4A)  begin errors++; $display("FAIL single_port: got %h want 4a", rx_data); end
    checks++; if (j_cyc.size() !== 1) begin errors++; $display("FAIL single_jump_len: got %0d want 1", j_cyc.size()); end
    checks++;
    if (j_cyc.size() < 1 || v_cyc.size() < 1 || j_cyc[0] !== v_cyc[0] + 1) begin
      errors++; $display("FAIL single_jump_time: jump cycles %0d, valid cycles %0d", j_cyc.size(), v_cyc.size());
    end
    checks++; if (fe_cyc.size() !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", fe_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g0, g1;
    clear_log();
    send_frame(8'h41, 1'b1);
    send_frame(8'h6A, 1'b1);
    hold(1'b1, 2 * BIT);
    g0 = (v_dat.size() > 0) ? v_dat[0] : 8'hxx;
    g1 = (v_dat.size() > 1) ? v_dat[1] : 8'hxx;
    checks++; if (v_cyc.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", v_cyc.size()); end
    checks++; if (g0 !== 8'h41)       begin errors++; $display("FAIL b2b_first: got %h want 41", g0); end
    checks++; if (g1 !== 8'h6A)       begin errors++; $display("FAIL b2b_second: got %h want 6a", g1); end
    checks++;
    if (j_cyc.size() !== 1 || v_cyc.size() < 2 || j_cyc[0] !== v_cyc[1] + 1) begin
      errors++; $display("FAIL b2b_jump: jump cycles %0d, want one after second byte", j_cyc.size());
    end
  endtask

  task automatic test_false_start();
    logic [7:0] got;
    clear_log();
    hold(1'b0, HALF / 2);
    hold(1'b1, 3 * BIT);
    checks++;
    if (v_cyc.size() !== 0 || fe_cyc.size() !== 0) begin
      errors++; $display("FAIL glitch_quiet: valid %0d ferr %0d want 0 0", v_cyc.size(), fe_cyc.size());
    end
    send_frame(8'h6A, 1'b1);
    hold(1'b1, 2 * BIT);
    got = (v_dat.size() > 0) ? v_dat[0] : 8'hxx;
    checks++;
    if (v_cyc.size() !== 1 || got !== 8'h6A) begin
      errors++; $display("FAIL glitch_follow: count %0d data %h want 1 6a", v_cyc.size(), got);
    end
    checks++; if (j_cyc.size() !== 1) begin errors++; $display("FAIL glitch_jump: got %0d want 1", j_cyc.size()); end
  endtask

  task automatic test_break();
    logic [7:0] got;
    clear_log();
    send_frame(8'h4A, 1'b0);
    hold(1'b0, 300);
    hold(1'b1, 2 * BIT);
    checks++; if (fe_cyc.size() !== 1) begin errors++; $display("FAIL break_ferr: got %0d want 1", fe_cyc.size()); end
    checks++;
    if (v_cyc.size() !== 0 || j_cyc.size() !== 0) begin
      errors++; $display("FAIL break_quiet: valid %0d jump %0d want 0 0", v_cyc.size(), j_cyc.size());
    end
    checks++; if (rx_data !== 8'h6A) begin errors++; $display("FAIL break_data_kept: got %h want 6a", rx_data); end
    clear_log();
    send_frame(8'h4A, 1'b1);
    hold(1'b1, 2 * BIT);
    got = (v_dat.size() > 0) ? v_dat[0] : 8'hxx;
    checks++;
    if (v_cyc.size() !== 1 || got !== 8'h4A || j_cyc.size() !== 1 || fe_cyc.size() !== 0) begin
      errors++; $display("FAIL break_recover: count %0d data %h jump %0d ferr %0d", v_cyc.size(), got, j_cyc.size(), fe_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [7:0] got;
    b = 8'hC5;
    clear_log();
    hold(1'b0, BIT);
    for (int i = 0; i < 3; i++) hold(b[i], BIT);
    hold(b[3], HALF);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    checks++;
    if (jump_btn !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs: jump %b data %h valid %b ferr %b tx %b", jump_btn, rx_data, rx_valid, frame_err, tx);
    end
    reset = 1'b0;
    hold(1'b1, 12 * BIT);
    checks++;
    if (v_cyc.size() !== 0 || fe_cyc.size() !== 0) begin
      errors++; $display("FAIL midreset_discard: valid %0d ferr %0d want 0 0", v_cyc.size(), fe_cyc.size());
    end
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 2 * BIT);
    got = (v_dat.size() > 0) ? v_dat[0] : 8'hxx;
    checks++;
    if (v_cyc.size() !== 1 || got !== 8'h3C) begin
      errors++; $display("FAIL midreset_follow: count %0d data %h want 1 3c", v_cyc.size(), got);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_j[$];
    logic [7:0] b;
    int         bad;
    clear_log();
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 2) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h4A : 8'h6A;
      else                           b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      hold(1'b1, $urandom_range(0, 20));
    end
    hold(1'b1, 3 * BIT);
    checks++;
    if (v_cyc.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", v_cyc.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= v_dat.size() || v_dat[i] !== exp_q[i]) bad++;
      if (is_jump(exp_q[i]) && i < v_cyc.size()) exp_j.push_back(v_cyc[i] + 1);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_data: got %0d wrong bytes want 0", bad); end
    bad = (j_cyc.size() == exp_j.size()) ? 0 : 1;
    for (int i = 0; i < exp_j.size() && i < j_cyc.size(); i++) if (j_cyc[i] !== exp_j[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL rand_jump: got %0d pulse cycles want %0d", j_cyc.size(), exp_j.size());
    end
  endtask

`ifdef BT_STATUS_TX_EN
  task automatic test_status_tx();
    logic [7:0] codes[2];
    logic [7:0] got;
    logic       start_bit, stop_bit;
    int         waited;
    codes[0] = 8'h58;
    codes[1] = 8'h41;
    for (int c = 0; c < 2; c++) begin
      game_alive = (c == 1);
      waited = 0;
      @(negedge clk);
      while (tx !== 1'b0 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      checks++; if (waited >= 50) begin errors++; $display("FAIL tx_start_%0d: no start bit within 50 cycles", c); end
      repeat (HALF) @(negedge clk);
      start_bit = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        got[i] = tx;
      end
      repeat (BIT) @(negedge clk);
      stop_bit = tx;
      checks++; if (start_bit !== 1'b0) begin errors++; $display("FAIL tx_startbit_%0d: got %b want 0", c, start_bit); end
      checks++; if (got !== codes[c])   begin errors++; $display("FAIL tx_code_%0d: got %h want %h", c, got, codes[c]); end
      checks++; if (stop_bit !== 1'b1)  begin errors++; $display("FAIL tx_stop_%0d: got %b want 1", c, stop_bit); end
      repeat (BIT) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_%0d: got %b want 1", c, tx); end
    end
  endtask
`else
  task automatic test_status_tx();
    int low;
    low = 0;
    for (int i = 0; i < 4 * BIT; i++) begin
      game_alive = (i / BIT) % 2 == 1;
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    checks++; if (low !== 0) begin errors++; $display("FAIL tx_quiet: got %0d non-idle cycles want 0", low); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_break();
    test_reset_mid();
    test_random();
    test_status_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
